// File: rtl/arith_issue_stage_if.sv
// Bundle between the arithmetic issue stage and its neighbours: the instruction
// byte stream, the ALU operand/result bus, and the architectural/debug outputs.
interface arith_issue_stage_if;
  logic [7:0] instrData;
  logic       instrValid;
  logic       instrReady;
  logic [2:0] aluOpcode;
  logic [7:0] aluOperandA;
  logic [7:0] aluOperandB;
  logic [7:0] aluResult;
  logic [7:0] accumulator;
  logic       zeroFlag;
  logic       illegalOp;
  logic [2:0] dbgSel;
  logic [7:0] dbgData;

  // View of the issue stage itself.
  modport slave (
    input  instrData, instrValid, aluResult, dbgSel,
    output instrReady, aluOpcode, aluOperandA, aluOperandB,
           accumulator, zeroFlag, illegalOp, dbgData
  );

  // View of the surrounding fetch/ALU/debug logic.
  modport master (
    output instrData, instrValid, aluResult, dbgSel,
    input  instrReady, aluOpcode, aluOperandA, aluOperandB,
           accumulator, zeroFlag, illegalOp, dbgData
  );
endinterface

// File: rtl/arith_issue_stage.sv
// Issue/writeback stage feeding the 8-bit ALU: decodes instruction bytes, owns
// the 8-entry register file (R0 = accumulator) and the zero flag.
module arith_issue_stage #(
  parameter bit IMM_ENABLE = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  arith_issue_stage_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_IMM     = 2'b01;
  localparam logic [1:0] ST_EXEC    = 2'b10;

  localparam logic [1:0] MODE_LDI   = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ST    = 2'b10;
  localparam logic [1:0] MODE_LD    = 2'b11;

  // Only ADD (100) and SUB (101) are accepted by the arithmetic path.
  function automatic logic is_legal_arith(input logic [2:0] op);
    return (op[2:1] == 2'b10);
  endfunction

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] regs_r [8];
  logic [2:0] sel_r;
  logic [2:0] op_r;
  logic       zero_flag_r;
  logic       illegal_r;

  logic       exec_s;
  logic       xfer_s;
  logic [1:0] mode_s;
  logic [2:0] byte_sel_s;
  logic [2:0] byte_op_s;

  logic       wr_en_s;
  logic [2:0] wr_idx_s;
  logic [7:0] wr_data_s;
  logic       latch_s;
  logic       illegal_nxt_s;
  logic       zero_we_s;

  assign exec_s     = (state_r == ST_EXEC);
  assign xfer_s     = bus.instrValid & ~exec_s;
  assign mode_s     = bus.instrData[7:6];
  assign byte_sel_s = bus.instrData[5:3];
  assign byte_op_s  = bus.instrData[2:0];

  // Decode and sequencing: at most one register-file write per cycle.
  always_comb begin
    state_nxt_s   = state_r;
    wr_en_s       = 1'b0;
    wr_idx_s      = 3'd0;
    wr_data_s     = 8'h00;
    latch_s       = 1'b0;
    illegal_nxt_s = 1'b0;
    zero_we_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          case (mode_s)
            MODE_LDI: begin
              if (IMM_ENABLE) begin
                state_nxt_s = ST_IMM;
                latch_s     = 1'b1;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end
            MODE_ARITH: begin
              if (is_legal_arith(byte_op_s)) begin
                state_nxt_s = ST_EXEC;
                latch_s     = 1'b1;
              end else begin
                illegal_nxt_s = 1'b1;
              end
            end
            MODE_ST: begin
              wr_en_s   = 1'b1;
              wr_idx_s  = byte_sel_s;
              wr_data_s = regs_r[3'd0];
            end
            MODE_LD: begin
              wr_en_s   = 1'b1;
              wr_idx_s  = 3'd0;
              wr_data_s = regs_r[byte_sel_s];
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_IMM: begin
        if (xfer_s) begin
          wr_en_s     = 1'b1;
          wr_idx_s    = sel_r;
          wr_data_s   = bus.instrData;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IMM;
        end
      end
      ST_EXEC: begin
        wr_en_s     = 1'b1;
        wr_idx_s    = 3'd0;
        wr_data_s   = bus.aluResult;
        zero_we_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched operands, register file and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= 3'd0;
      op_r        <= 3'd0;
      zero_flag_r <= 1'b0;
      illegal_r   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      state_r   <= state_nxt_s;
      illegal_r <= illegal_nxt_s;
      if (latch_s) begin
        sel_r <= byte_sel_s;
        op_r  <= byte_op_s;
      end
      if (wr_en_s) begin
        regs_r[wr_idx_s] <= wr_data_s;
      end
      if (zero_we_s) begin
        zero_flag_r <= (bus.aluResult == 8'h00);
      end
    end
  end

  // ALU drive: quiet (opcode 000, zero operands) except during EXEC.
  always_comb begin
    bus.aluOpcode   = 3'b000;
    bus.aluOperandA = 8'h00;
    bus.aluOperandB = 8'h00;
    if (exec_s) begin
      bus.aluOpcode   = op_r;
      bus.aluOperandA = regs_r[3'd0];
      bus.aluOperandB = regs_r[sel_r];
    end else begin
      bus.aluOpcode   = 3'b000;
      bus.aluOperandA = 8'h00;
      bus.aluOperandB = 8'h00;
    end
  end

  assign bus.instrReady  = ~exec_s;
  assign bus.accumulator = regs_r[3'd0];
  assign bus.zeroFlag    = zero_flag_r;
  assign bus.illegalOp   = illegal_r;
  assign bus.dbgData     = regs_r[bus.dbgSel];

endmodule

// File: tb/tb_arith_issue_stage.sv
// Directed, table-driven bench for arith_issue_stage with a behavioural ALU;
// a second instance covers IMM_ENABLE=0.
module tb_arith_issue_stage;

  logic clock;
  logic reset1;
  logic reset2;
  int   checks;
  int   errors;

  arith_issue_stage_if bus1();
  arith_issue_stage_if bus2();

  arith_issue_stage #(.IMM_ENABLE(1'b1)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));
  arith_issue_stage #(.IMM_ENABLE(1'b0)) dut2 (.clock(clock), .reset(reset2), .bus(bus2));

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b100:  return a + b;
      3'b101:  return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus1.aluResult = alu(bus1.aluOpcode, bus1.aluOperandA, bus1.aluOperandB);
  assign bus2.aluResult = alu(bus2.aluOpcode, bus2.aluOperandA, bus2.aluOperandB);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] ds;
    logic       rdy;
    logic [7:0] acc;
    logic       z;
    logic       ill;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] dbg;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic dbg_all_zero(input string tag);
    for (int r = 0; r < 8; r++) begin
      bus1.dbgSel = r[2:0];
      #1;
      chk($sformatf("%s dbg R%0d", tag, r), bus1.dbgData, 8'h00);
    end
  endtask

  int accepts;

  initial begin
    checks = 0;
    errors = 0;
    reset1 = 1'b1;
    reset2 = 1'b1;
    bus1.instrValid = 1'b0; bus1.instrData = 8'h00; bus1.dbgSel = 3'd0;
    bus2.instrValid = 1'b0; bus2.instrData = 8'h00; bus2.dbgSel = 3'd0;

    //          v     d      ds    rdy   acc    z     ill   op      a      b      dbg
    vq.push_back('{1'b1, 8'h00, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h05, 3'd0, 1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h05});
    vq.push_back('{1'b1, 8'h08, 3'd1, 1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h03, 3'd1, 1'b1, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h03});
    vq.push_back('{1'b1, 8'h4C, 3'd1, 1'b0, 8'h05, 1'b0, 1'b0, 3'd4, 8'h05, 8'h03, 8'h03});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h08});
    vq.push_back('{1'b1, 8'h00, 3'd0, 1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h08});
    vq.push_back('{1'b1, 8'h03, 3'd0, 1'b1, 8'h03, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h03});
    vq.push_back('{1'b1, 8'h4D, 3'd1, 1'b0, 8'h03, 1'b0, 1'b0, 3'd5, 8'h03, 8'h03, 8'h03});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b1, 8'h10, 3'd2, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h02, 3'd2, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h02});
    vq.push_back('{1'b1, 8'h55, 3'd2, 1'b0, 8'h01, 1'b1, 1'b0, 3'd5, 8'h01, 8'h02, 8'h02});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF});
    vq.push_back('{1'b1, 8'h08, 3'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h03});
    vq.push_back('{1'b1, 8'h01, 3'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b1, 8'h4C, 3'd1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd4, 8'hFF, 8'h01, 8'h01});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h4A, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00});
    vq.push_back('{1'b1, 8'h4F, 3'd1, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b1, 8'h48, 3'd1, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b0, 8'h00, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b1, 8'h08, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01});
    vq.push_back('{1'b1, 8'h5A, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h5A});
    vq.push_back('{1'b1, 8'hC8, 3'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h5A});
    vq.push_back('{1'b1, 8'h98, 3'd3, 1'b1, 8'h5A, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h5A});
    vq.push_back('{1'b0, 8'h00, 3'd1, 1'b1, 8'h5A, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h5A});
    vq.push_back('{1'b1, 8'h44, 3'd0, 1'b0, 8'h5A, 1'b1, 1'b0, 3'd4, 8'h5A, 8'h5A, 8'h5A});
    vq.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 8'hB4, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hB4});
    vq.push_back('{1'b1, 8'h80, 3'd0, 1'b1, 8'hB4, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hB4});

    tick();
    tick();
    reset1 = 1'b0;
    reset2 = 1'b0;
    tick();
    chk("reset ready", {7'd0, bus1.instrReady}, 8'h01);
    chk("reset acc", bus1.accumulator, 8'h00);
    chk("reset zero", {7'd0, bus1.zeroFlag}, 8'h00);
    chk("reset illegal", {7'd0, bus1.illegalOp}, 8'h00);
    chk("reset aluop", {5'd0, bus1.aluOpcode}, 8'h00);
    dbg_all_zero("reset");

    for (int i = 0; i < vq.size(); i++) begin
      bus1.instrValid = vq[i].v;
      bus1.instrData  = vq[i].d;
      bus1.dbgSel     = vq[i].ds;
      tick();
      chk($sformatf("row%0d ready", i), {7'd0, bus1.instrReady}, {7'd0, vq[i].rdy});
      chk($sformatf("row%0d acc", i), bus1.accumulator, vq[i].acc);
      chk($sformatf("row%0d zero", i), {7'd0, bus1.zeroFlag}, {7'd0, vq[i].z});
      chk($sformatf("row%0d illegal", i), {7'd0, bus1.illegalOp}, {7'd0, vq[i].ill});
      chk($sformatf("row%0d aluop", i), {5'd0, bus1.aluOpcode}, {5'd0, vq[i].op});
      chk($sformatf("row%0d opA", i), bus1.aluOperandA, vq[i].a);
      chk($sformatf("row%0d opB", i), bus1.aluOperandB, vq[i].b);
      chk($sformatf("row%0d dbg", i), bus1.dbgData, vq[i].dbg);
    end

    // Back-to-back ADD R1 with valid held high: 0xB4 + 3*0x5A = 0xC2.
    accepts = 0;
    bus1.instrValid = 1'b1;
    bus1.instrData  = 8'h4C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus1.instrValid && bus1.instrReady) accepts++;
      tick();
      chk($sformatf("b2b ready%0d", i), {7'd0, bus1.instrReady}, (i % 2 == 1) ? 8'h01 : 8'h00);
    end
    bus1.instrValid = 1'b0;
    chk("b2b accepts", accepts[7:0], 8'd3);
    chk("b2b acc", bus1.accumulator, 8'hC2);

    // Reset while in IMM, with a simultaneous valid byte: both discarded.
    bus1.instrValid = 1'b1;
    bus1.instrData  = 8'h10;
    tick();
    chk("imm ready", {7'd0, bus1.instrReady}, 8'h01);
    reset1 = 1'b1;
    bus1.instrData = 8'h77;
    tick();
    reset1 = 1'b0;
    bus1.instrValid = 1'b0;
    tick();
    chk("rstimm ready", {7'd0, bus1.instrReady}, 8'h01);
    chk("rstimm acc", bus1.accumulator, 8'h00);
    chk("rstimm zero", {7'd0, bus1.zeroFlag}, 8'h00);
    dbg_all_zero("rstimm");
    bus1.instrValid = 1'b1;
    bus1.instrData  = 8'h4C;
    tick();
    bus1.instrValid = 1'b0;
    chk("rstimm exec ready", {7'd0, bus1.instrReady}, 8'h00);
    chk("rstimm exec op", {5'd0, bus1.aluOpcode}, 8'h04);
    tick();
    chk("rstimm add acc", bus1.accumulator, 8'h00);
    chk("rstimm add zero", {7'd0, bus1.zeroFlag}, 8'h01);
    bus1.dbgSel = 3'd2;
    #1;
    chk("rstimm R2", bus1.dbgData, 8'h00);

    // Reset during EXEC discards the writeback of 0 + 7.
    bus1.instrValid = 1'b1;
    bus1.instrData  = 8'h08;
    tick();
    bus1.instrData  = 8'h07;
    tick();
    bus1.instrData  = 8'h4C;
    tick();
    bus1.instrValid = 1'b0;
    chk("rstexec op", {5'd0, bus1.aluOpcode}, 8'h04);
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    chk("rstexec acc", bus1.accumulator, 8'h00);
    chk("rstexec zero", {7'd0, bus1.zeroFlag}, 8'h00);
    tick();
    chk("rstexec ready", {7'd0, bus1.instrReady}, 8'h01);
    chk("rstexec acc2", bus1.accumulator, 8'h00);

    // IMM_ENABLE=0: 0x00 is a NOP, so 0x4C executes as ADD.
    bus2.instrValid = 1'b1;
    bus2.instrData  = 8'h00;
    tick();
    chk("noimm nop ready", {7'd0, bus2.instrReady}, 8'h01);
    bus2.instrData = 8'h4C;
    tick();
    bus2.instrValid = 1'b0;
    chk("noimm exec ready", {7'd0, bus2.instrReady}, 8'h00);
    chk("noimm exec op", {5'd0, bus2.aluOpcode}, 8'h04);
    tick();
    chk("noimm acc", bus2.accumulator, 8'h00);
    chk("noimm zero", {7'd0, bus2.zeroFlag}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_issue_stage.md
Name: arith_issue_stage

Overview:
- Issue/writeback stage directly upstream of the arithmetic unit in the 8-bit CPU.
- Accepts instruction bytes over a valid/ready handshake, decodes them, and holds an 8-entry register file (R0 = accumulator).
- Drives the ALU opcode and operands, then writes the ALU result back into R0 and updates a zero flag.

Parameters:
- IMM_ENABLE, 1: 1 = mode 00 is load-immediate (two-byte instruction); 0 = mode 00 is a one-cycle NOP.

Ports:
- clock  input  1  single system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- instrData  input  8  instruction or immediate byte
- instrValid  input  1  instrData valid this cycle
- instrReady  output  1  stage can accept a byte this cycle
- aluOpcode  output  3  to ALU opcode
- aluOperandA  output  8  to ALU operandA (always R0)
- aluOperandB  output  8  to ALU operandB (R[sel])
- aluResult  input  8  from ALU result (combinational)
- accumulator  output  8  current R0
- zeroFlag  output  1  registered: last ALU result was 0
- illegalOp  output  1  one-cycle pulse on rejected arithmetic opcode
- dbgSel  input  3  debug register select
- dbgData  output  8  combinational R[dbgSel]

Behaviour:
- Instruction byte: [7:6] mode, [5:3] sel, [2:0] op. A byte transfers on a rising edge with instrValid && instrReady.
- Modes:
  - 00 LDI: the next transferred byte is written to R[sel]; op ignored.
  - 01 ARITH: R0 := R0 op R[sel]. Legal op = 100 (ADD), 101 (SUB).
  - 10 ST: R[sel] := R0.
  - 11 LD: R0 := R[sel].
- States:
  - IDLE: instrReady=1.
    - ARITH with op[2:1]==10 goes to EXEC.
    - ARITH with any other op: illegalOp=1 the following cycle; no register or flag change; stays IDLE.
    - LDI (IMM_ENABLE=1) goes to IMM.
    - ST/LD complete on the transfer edge; stays IDLE.
  - IMM: instrReady=1. The next transferred byte is written to R[latched sel], then IDLE. With no valid byte, the stage waits indefinitely.
  - EXEC: instrReady=0. Drives aluOpcode=latched op, aluOperandA=R0, aluOperandB=R[latched sel]. On the edge ending EXEC: R0 := aluResult, zeroFlag := (aluResult==0), then IDLE.
- Outside EXEC: aluOpcode=000, aluOperandA=aluOperandB=0. ALU output is 0 for opcode 000.
- Latency: ARITH accepted at edge N; R0/zeroFlag valid after edge N+1. Peak throughput is one ARITH per 2 cycles.
- Operand capture: sel and op latch on the accept edge. aluOperandB reads R[sel] live during EXEC, which is safe because no other write can occur in EXEC.
- sel=0:
  - ARITH uses R0 as both operands (ADD doubles, SUB gives 0).
  - ST/LD to R0 are no-ops.
  - LDI to R0 loads the accumulator.
- Arithmetic: 8-bit modulo 2^8. No carry/borrow output; wrap-around is silent.
- zeroFlag: changes only on EXEC completion; LDI/LD/ST leave it unchanged.
- Reset:
  - All registers, zeroFlag and illegalOp go to 0; state goes to IDLE.
  - instrReady=1 in the cycle after reset deasserts.
  - Reset during IMM discards the pending load. Reset during EXEC discards the writeback.
  - Reset has priority over any simultaneous transfer.
- IMM_ENABLE=0: mode 00 is accepted and ignored; stays IDLE.
- dbgData: purely combinational, so writes are visible the cycle after their edge.

Test Plan:
- Reset, then LDI R0 (0x00, 0x05), then LDI R1 (0x08, 0x03), then ADD R1 (0x4C) -> aluOperandA=5, aluOperandB=3, aluOpcode=100 in EXEC; accumulator=8, zeroFlag=0 one cycle after EXEC.
- From R0=3, R1=3: SUB R1 (0x4D) -> accumulator=0, zeroFlag=1. Then R0=0x01, R2=0x02, SUB R2 -> accumulator=0xFF (wrap), zeroFlag=0. Also ADD 0xFF+0x01 -> 0x00, zeroFlag=1.
- Illegal ARITH 0x4A -> illegalOp pulses exactly 1 cycle, accumulator/zeroFlag unchanged, instrReady stays 1.
- instrValid held high with back-to-back ARITH bytes -> instrReady low during each EXEC, exactly one accept per 2 cycles, no byte lost or duplicated. Also LD R1 (0xC8) then ST R3 (0x98) -> dbgSel=3 reads the R1 value.
- Reset asserted while in IMM (after 0x10) -> next byte 0x4C is decoded as ADD, not loaded into R2; all dbgData reads 0 before any load.
- IMM_ENABLE=0: 0x00 then 0x4C -> 0x4C executes as ADD (R0+R1 = 0+0); zeroFlag=1.
